// File: rtl/pacman_pkg.sv
// Shared types and constants for the pac-man mover: directions, FSM states,
// keycodes and Wall/probe bit positions ({up,down,left,right} = [3:0]).
package pacman_pkg;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        LEFT  = 3'd1,
        RIGHT = 3'd2,
        UP    = 3'd3,
        DOWN  = 3'd4
    } dir_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MOVING  = 2'd1,
        BLOCKED = 2'd2
    } state_t;

    localparam logic [7:0] KEY_LEFT  = 8'h04;
    localparam logic [7:0] KEY_RIGHT = 8'h07;
    localparam logic [7:0] KEY_DOWN  = 8'h16;
    localparam logic [7:0] KEY_UP    = 8'h1A;

    function automatic dir_t key_to_dir(input logic [7:0] k);
        case (k)
            KEY_LEFT:  return LEFT;
            KEY_RIGHT: return RIGHT;
            KEY_DOWN:  return DOWN;
            KEY_UP:    return UP;
            default:   return NONE;
        endcase
    endfunction

    function automatic dir_t reverse_of(input dir_t d);
        case (d)
            LEFT:    return RIGHT;
            RIGHT:   return LEFT;
            UP:      return DOWN;
            DOWN:    return UP;
            default: return NONE;
        endcase
    endfunction

    // blk uses the Wall bit order {up,down,left,right}
    function automatic logic dir_blocked(input dir_t d, input logic [3:0] blk);
        case (d)
            UP:      return blk[3];
            DOWN:    return blk[2];
            LEFT:    return blk[1];
            RIGHT:   return blk[0];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pacman_if.sv
// Game-side bus of the mover: key/wall inputs, probe points, position and status.
interface pacman_if #(parameter int W = 10);
    import pacman_pkg::*;

    logic [7:0]          keycode;
    logic [3:0]          Wall;
    logic [3:0][W-1:0]   ProbeX;
    logic [3:0][W-1:0]   ProbeY;
    logic [W-1:0]        BallX;
    logic [W-1:0]        BallY;
    logic [W-1:0]        BallS;
    dir_t                Dir;
    state_t              State;
    logic [3:0]          No_Move;

    modport master (output keycode, Wall,
                    input  ProbeX, ProbeY, BallX, BallY, BallS, Dir, State, No_Move);
    modport slave  (input  keycode, Wall,
                    output ProbeX, ProbeY, BallX, BallY, BallS, Dir, State, No_Move);
endinterface

// File: rtl/pacman_turn_buffer.sv
// Keycode decode plus one-entry pending-turn register. A key arriving this
// cycle bypasses the register so it can be taken immediately.
module pacman_turn_buffer
    import pacman_pkg::*;
(
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic       take,
    output dir_t       req
);
    dir_t pend_q;
    dir_t key_dir;

    assign key_dir = key_to_dir(keycode);
    assign req     = (key_dir != NONE) ? key_dir : pend_q;

    always_ff @(posedge frame_clk) begin
        if (Reset)                 pend_q <= NONE;
        else if (take)             pend_q <= NONE;
        else if (key_dir != NONE)  pend_q <= key_dir;
    end
endmodule

// File: rtl/pacman_mover.sv
// Grid-aligned sprite mover with pending turns and wall probes.
// Optional horizontal tunnel wrap: define PACMAN_TUNNEL_WRAP_EN.
module pacman_mover
    import pacman_pkg::*;
#(
    parameter int W        = 10,
    parameter int X_CENTER = 320,
    parameter int Y_CENTER = 274,
    parameter int SIZE     = 7,
    parameter int STEP     = 1,
    parameter int TILE     = 8,
    parameter int X_MAX    = 639
) (
    input  logic    frame_clk,
    input  logic    Reset,
    pacman_if.slave bus
);
    localparam logic [W-1:0] XC     = W'(X_CENTER);
    localparam logic [W-1:0] YC     = W'(Y_CENTER);
    localparam logic [W-1:0] SIZE_W = W'(SIZE);
    localparam logic [W-1:0] STEP_W = W'(STEP);
    localparam logic [W-1:0] REACH  = W'(SIZE + STEP);
    localparam logic [W-1:0] TMASK  = W'(TILE - 1);
    localparam logic [W-1:0] XMAX_W = W'(X_MAX);
`ifdef PACMAN_TUNNEL_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic [W-1:0] ball_x, ball_y, nx, ny;
    dir_t         dir_q, nd, req;
    state_t       state_q, ns;
    logic [3:0]   no_move_q, edge_blk, blk;
    logic         align_x, align_y, take, move;

    pacman_turn_buffer u_turn (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .keycode   (bus.keycode),
        .take      (take),
        .req       (req)
    );

    always_comb begin
        bus.ProbeX[3] = ball_x;          bus.ProbeY[3] = ball_y - REACH;
        bus.ProbeX[2] = ball_x;          bus.ProbeY[2] = ball_y + REACH;
        bus.ProbeX[1] = ball_x - REACH;  bus.ProbeY[1] = ball_y;
        bus.ProbeX[0] = ball_x + REACH;  bus.ProbeY[0] = ball_y;
    end

    // Without the tunnel the screen edges act as extra left/right walls.
`ifdef PACMAN_TUNNEL_WRAP_EN
    assign edge_blk = 4'b0000;
`else
    assign edge_blk = {2'b00, ball_x <= SIZE_W, ball_x >= XMAX_W - SIZE_W};
`endif
    assign blk = bus.Wall | edge_blk;

    assign align_x = ((ball_x - XC) & TMASK) == '0;
    assign align_y = ((ball_y - YC) & TMASK) == '0;

    assign take = (req != NONE) && !dir_blocked(req, blk) &&
                  ((req == reverse_of(dir_q)) || (dir_q == NONE) ||
                   (((req == UP) || (req == DOWN)) && align_x) ||
                   (((req == LEFT) || (req == RIGHT)) && align_y));

    assign nd   = take ? req : dir_q;
    // BLOCKED only resumes motion the cycle after its wall clears, unless a turn is taken.
    assign move = ((state_q == MOVING) || take) && (nd != NONE) && !dir_blocked(nd, blk);
    assign ns   = (nd == NONE) ? IDLE : (dir_blocked(nd, blk) ? BLOCKED : MOVING);

    always_comb begin
        nx = ball_x;
        ny = ball_y;
        if (move) begin
            case (nd)
                LEFT:    nx = (WRAP && (ball_x < STEP_W)) ? XMAX_W : ball_x - STEP_W;
                RIGHT:   nx = (WRAP && (ball_x > XMAX_W - STEP_W)) ? '0 : ball_x + STEP_W;
                UP:      ny = ball_y - STEP_W;
                DOWN:    ny = ball_y + STEP_W;
                default: ;
            endcase
        end
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            ball_x    <= XC;
            ball_y    <= YC;
            dir_q     <= NONE;
            state_q   <= IDLE;
            no_move_q <= '0;
        end else begin
            ball_x    <= nx;
            ball_y    <= ny;
            dir_q     <= nd;
            state_q   <= ns;
            no_move_q <= bus.Wall;
        end
    end

    assign bus.BallX   = ball_x;
    assign bus.BallY   = ball_y;
    assign bus.BallS   = SIZE_W;
    assign bus.Dir     = dir_q;
    assign bus.State   = state_q;
    assign bus.No_Move = no_move_q;
endmodule

// File: tb/tb_pacman_mover.sv
// Directed bench for pacman_mover with hand-computed positions and states.
module tb_pacman_mover;
    import pacman_pkg::*;

    logic frame_clk = 1'b0;
    logic Reset;
    int   checks = 0;
    int   failures = 0;

    pacman_if #(.W(10)) bus ();

    pacman_mover #(.W(10), .X_CENTER(320), .Y_CENTER(274), .SIZE(7), .STEP(1),
                   .TILE(8), .X_MAX(639)) dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (bus)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic step(input int n);
        repeat (n) @(posedge frame_clk);
        #1;
    endtask

    task automatic do_reset();
        bus.keycode = 8'h00;
        bus.Wall    = 4'b0000;
        Reset = 1'b1;
        step(1);
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.keycode = 8'h00;
        bus.Wall    = 4'hF;
        Reset = 1'b1;
        step(2);
        checks++; if (bus.BallX !== 10'd320) begin failures++; $display("FAIL reset_x got %0d want 320", bus.BallX); end
        checks++; if (bus.BallY !== 10'd274) begin failures++; $display("FAIL reset_y got %0d want 274", bus.BallY); end
        checks++; if (bus.Dir !== NONE) begin failures++; $display("FAIL reset_dir got %0d want 0", bus.Dir); end
        checks++; if (bus.State !== IDLE) begin failures++; $display("FAIL reset_state got %0d want 0", bus.State); end
        checks++; if (bus.No_Move !== 4'b0000) begin failures++; $display("FAIL reset_nomove got %b want 0000", bus.No_Move); end
        checks++; if (bus.BallS !== 10'd7) begin failures++; $display("FAIL reset_size got %0d want 7", bus.BallS); end
        checks++; if (bus.ProbeX[0] !== 10'd328 || bus.ProbeX[1] !== 10'd312) begin failures++; $display("FAIL probe_x got r=%0d l=%0d want 328 312", bus.ProbeX[0], bus.ProbeX[1]); end
        checks++; if (bus.ProbeY[3] !== 10'd266 || bus.ProbeY[2] !== 10'd282) begin failures++; $display("FAIL probe_y got u=%0d d=%0d want 266 282", bus.ProbeY[3], bus.ProbeY[2]); end
        Reset = 1'b0;
        bus.Wall = 4'b0000;
    endtask

    task automatic test_move_left();
        do_reset();
        bus.keycode = KEY_LEFT;
        step(1);
        bus.keycode = 8'h00;
        checks++; if (bus.Dir !== LEFT || bus.State !== MOVING) begin failures++; $display("FAIL left_take got dir=%0d st=%0d want 1 1", bus.Dir, bus.State); end
        checks++; if (bus.BallX !== 10'd319) begin failures++; $display("FAIL left_first got %0d want 319", bus.BallX); end
        step(4);
        checks++; if (bus.BallX !== 10'd315 || bus.BallY !== 10'd274) begin failures++; $display("FAIL left_5 got %0d,%0d want 315,274", bus.BallX, bus.BallY); end
    endtask

    task automatic test_turn_align();
        do_reset();
        bus.keycode = KEY_LEFT;
        step(1);
        bus.keycode = 8'h00;
        step(2);
        checks++; if (bus.BallX !== 10'd317) begin failures++; $display("FAIL turn_pre got %0d want 317", bus.BallX); end
        bus.keycode = KEY_UP;
        step(1);
        bus.keycode = 8'h00;
        checks++; if (bus.Dir !== LEFT || bus.BallX !== 10'd316) begin failures++; $display("FAIL turn_early got dir=%0d x=%0d want 1 316", bus.Dir, bus.BallX); end
        step(4);
        checks++; if (bus.Dir !== LEFT || bus.BallX !== 10'd312) begin failures++; $display("FAIL turn_wait got dir=%0d x=%0d want 1 312", bus.Dir, bus.BallX); end
        step(1);
        checks++; if (bus.Dir !== UP || bus.BallX !== 10'd312 || bus.BallY !== 10'd273) begin failures++; $display("FAIL turn_take got dir=%0d x=%0d y=%0d want 3 312 273", bus.Dir, bus.BallX, bus.BallY); end
        step(1);
        checks++; if (bus.BallY !== 10'd272 || bus.BallX !== 10'd312) begin failures++; $display("FAIL turn_up got %0d,%0d want 312,272", bus.BallX, bus.BallY); end
    endtask

    task automatic test_wall_block();
        do_reset();
        bus.keycode = KEY_RIGHT;
        step(1);
        bus.keycode = 8'h00;
        step(2);
        checks++; if (bus.BallX !== 10'd323) begin failures++; $display("FAIL wall_pre got %0d want 323", bus.BallX); end
        bus.Wall = 4'b0001;
        step(1);
        checks++; if (bus.State !== BLOCKED || bus.BallX !== 10'd323) begin failures++; $display("FAIL wall_hit got st=%0d x=%0d want 2 323", bus.State, bus.BallX); end
        checks++; if (bus.No_Move !== 4'b0001) begin failures++; $display("FAIL wall_nomove got %b want 0001", bus.No_Move); end
        step(2);
        checks++; if (bus.State !== BLOCKED || bus.BallX !== 10'd323) begin failures++; $display("FAIL wall_hold got st=%0d x=%0d want 2 323", bus.State, bus.BallX); end
        bus.Wall = 4'b0000;
        step(1);
        checks++; if (bus.State !== MOVING || bus.BallX !== 10'd323 || bus.No_Move !== 4'b0000) begin failures++; $display("FAIL wall_clear got st=%0d x=%0d nm=%b want 1 323 0000", bus.State, bus.BallX, bus.No_Move); end
        step(1);
        checks++; if (bus.BallX !== 10'd324) begin failures++; $display("FAIL wall_resume got %0d want 324", bus.BallX); end
    endtask

    task automatic test_reversal();
        do_reset();
        bus.keycode = KEY_LEFT;
        step(1);
        bus.keycode = 8'h00;
        step(1);
        checks++; if (bus.BallX !== 10'd318) begin failures++; $display("FAIL rev_pre got %0d want 318", bus.BallX); end
        bus.keycode = KEY_RIGHT;
        step(1);
        bus.keycode = 8'h00;
        checks++; if (bus.Dir !== RIGHT || bus.BallX !== 10'd319) begin failures++; $display("FAIL rev_take got dir=%0d x=%0d want 2 319", bus.Dir, bus.BallX); end
        step(1);
        checks++; if (bus.BallX !== 10'd320) begin failures++; $display("FAIL rev_move got %0d want 320", bus.BallX); end
    endtask

    task automatic test_pending_blocked();
        do_reset();
        bus.Wall = 4'b1000;
        bus.keycode = KEY_UP;
        step(1);
        bus.keycode = 8'h00;
        checks++; if (bus.State !== IDLE || bus.Dir !== NONE) begin failures++; $display("FAIL pend_blocked got st=%0d dir=%0d want 0 0", bus.State, bus.Dir); end
        checks++; if (bus.No_Move !== 4'b1000) begin failures++; $display("FAIL pend_nomove got %b want 1000", bus.No_Move); end
        bus.Wall = 4'b0000;
        step(1);
        checks++; if (bus.Dir !== UP || bus.State !== MOVING || bus.BallY !== 10'd273) begin failures++; $display("FAIL pend_take got dir=%0d st=%0d y=%0d want 3 1 273", bus.Dir, bus.State, bus.BallY); end
    endtask

    task automatic test_edge();
        do_reset();
        bus.keycode = KEY_LEFT;
        step(1);
        bus.keycode = 8'h00;
`ifdef PACMAN_TUNNEL_WRAP_EN
        step(319);
        checks++; if (bus.BallX !== 10'd0 || bus.State !== MOVING) begin failures++; $display("FAIL wrap_zero got x=%0d st=%0d want 0 1", bus.BallX, bus.State); end
        step(1);
        checks++; if (bus.BallX !== 10'd639) begin failures++; $display("FAIL wrap_jump got %0d want 639", bus.BallX); end
`else
        step(312);
        checks++; if (bus.BallX !== 10'd7 || bus.State !== MOVING) begin failures++; $display("FAIL edge_reach got x=%0d st=%0d want 7 1", bus.BallX, bus.State); end
        step(1);
        checks++; if (bus.BallX !== 10'd7 || bus.State !== BLOCKED) begin failures++; $display("FAIL edge_block got x=%0d st=%0d want 7 2", bus.BallX, bus.State); end
        bus.keycode = KEY_RIGHT;
        step(1);
        bus.keycode = 8'h00;
        checks++; if (bus.BallX !== 10'd8 || bus.State !== MOVING) begin failures++; $display("FAIL edge_escape got x=%0d st=%0d want 8 1", bus.BallX, bus.State); end
`endif
    endtask

    task automatic test_reset_override();
        do_reset();
        bus.keycode = KEY_LEFT;
        step(1);
        bus.keycode = 8'h00;
        step(2);
        bus.keycode = KEY_UP;
        step(1);
        checks++; if (bus.Dir !== LEFT || bus.BallX !== 10'd316) begin failures++; $display("FAIL ovr_pre got dir=%0d x=%0d want 1 316", bus.Dir, bus.BallX); end
        bus.keycode = KEY_RIGHT;
        bus.Wall = 4'b0110;
        Reset = 1'b1;
        step(1);
        Reset = 1'b0;
        bus.keycode = 8'h00;
        bus.Wall = 4'b0000;
        checks++; if (bus.BallX !== 10'd320 || bus.BallY !== 10'd274) begin failures++; $display("FAIL ovr_pos got %0d,%0d want 320,274", bus.BallX, bus.BallY); end
        checks++; if (bus.State !== IDLE || bus.Dir !== NONE || bus.No_Move !== 4'b0000) begin failures++; $display("FAIL ovr_state got st=%0d dir=%0d nm=%b want 0 0 0000", bus.State, bus.Dir, bus.No_Move); end
        step(3);
        checks++; if (bus.State !== IDLE || bus.Dir !== NONE || bus.BallY !== 10'd274) begin failures++; $display("FAIL ovr_pend got st=%0d dir=%0d y=%0d want 0 0 274", bus.State, bus.Dir, bus.BallY); end
    endtask

    initial begin
        Reset = 1'b1;
        bus.keycode = 8'h00;
        bus.Wall = 4'b0000;
        test_reset();
        test_move_left();
        test_turn_align();
        test_wall_block();
        test_reversal();
        test_pending_blocked();
        test_edge();
        test_reset_override();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
